// File: rtl/cntr_seq_pkg.sv
// cntr_seq_pkg: FSM states, cfg_wr_data field layout and entry unpacking for cntr_cfg_sequencer.
package cntr_seq_pkg;

    typedef enum logic [2:0] {IDLE, LOAD, RUN, NEXT, DONE} state_t;

    // Field slots within a packed entry, counted from the LSB in units of CNT_W.
    localparam int INCR_SLOT  = 0;
    localparam int IND_SLOT   = 1;
    localparam int START_SLOT = 2;
    localparam int MAX_W      = 16;
    localparam int ENTRY_W    = 3 * MAX_W;

    function automatic logic [MAX_W-1:0] unpack_field(input logic [ENTRY_W-1:0] entry, input int slot, input int w);
        return MAX_W'((entry >> (slot * w)) & ((ENTRY_W'(1) << w) - ENTRY_W'(1)));
    endfunction

endpackage

// File: rtl/cntr_seq_if.sv
// cntr_seq_if: host write port, counter control and status signals of cntr_cfg_sequencer.
interface cntr_seq_if #(
    parameter int NUM_CFG = 4,
    parameter int CNT_W   = 4
);
    localparam int AW = $clog2(NUM_CFG);

    logic               cfg_wr_en;
    logic [AW-1:0]      cfg_wr_addr;
    logic [3*CNT_W-1:0] cfg_wr_data;
    logic               go;
    logic               ind;
    logic               cntr_reset;
    logic [CNT_W-1:0]   cntr_start;
    logic [CNT_W-1:0]   ind_val;
    logic [CNT_W-1:0]   incr;
    logic               busy;
    logic               done;
    logic [NUM_CFG-1:0] pass_mask;

    modport master (
        output cfg_wr_en, cfg_wr_addr, cfg_wr_data, go, ind,
        input  cntr_reset, cntr_start, ind_val, incr, busy, done, pass_mask
    );

    modport slave (
        input  cfg_wr_en, cfg_wr_addr, cfg_wr_data, go, ind,
        output cntr_reset, cntr_start, ind_val, incr, busy, done, pass_mask
    );

endinterface

// File: rtl/cntr_seq_timer.sv
// cntr_seq_timer: clear/enable cycle counter flagging expired on its TIMEOUT-th counted cycle.
module cntr_seq_timer #(
    parameter int TIMEOUT = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic en,
    output logic expired
);
    localparam int TW = $clog2(TIMEOUT + 1);

    logic [TW-1:0] timer;

    always_ff @(posedge clk) begin
        if (reset || clr)
            timer <= '0;
        else if (en)
            timer <= timer + 1'b1;
    end

    assign expired = timer == TW'(TIMEOUT - 1);

endmodule

// File: rtl/cntr_cfg_sequencer.sv
// cntr_cfg_sequencer: steps a cntr_config instance through a table of configurations and records pass/fail.
// Define CNTR_SEQ_LOOP_EN to restart from DONE while go stays high.
module cntr_cfg_sequencer
    import cntr_seq_pkg::*;
#(
    parameter int NUM_CFG = 4,
    parameter int CNT_W   = 4,
    parameter int TIMEOUT = 16
) (
    input logic      clk,
    input logic      reset,
    cntr_seq_if.slave bus
);
    localparam int IW = $clog2(NUM_CFG);
`ifdef CNTR_SEQ_LOOP_EN
    localparam bit LOOP = 1'b1;
`else
    localparam bit LOOP = 1'b0;
`endif

    state_t             state, nxt;
    logic [IW-1:0]      idx;
    logic [3*CNT_W-1:0] cfg_tbl [NUM_CFG];
    logic [3*CNT_W-1:0] entry;
    logic [NUM_CFG-1:0] pass_mask;
    logic               expired, last, restart;
    logic               busy, done, cntr_reset;

    assign last    = idx == IW'(NUM_CFG - 1);
    assign restart = bus.go && (state == IDLE || (LOOP && state == DONE));

    always_comb begin
        nxt        = state;
        busy       = 1'b0;
        done       = 1'b0;
        cntr_reset = 1'b1;
        unique case (state)
            IDLE: nxt = bus.go ? LOAD : IDLE;
            LOAD: begin
                busy = 1'b1;
                nxt  = RUN;
            end
            RUN: begin
                busy       = 1'b1;
                cntr_reset = 1'b0;
                nxt        = (bus.ind || expired) ? NEXT : RUN;
            end
            NEXT: begin
                busy = 1'b1;
                nxt  = last ? DONE : LOAD;
            end
            DONE: begin
                done = 1'b1;
                busy = restart;
                nxt  = restart ? LOAD : IDLE;
            end
            default: nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            idx       <= '0;
            pass_mask <= '0;
            cfg_tbl   <= '{default: '0};
        end else begin
            state <= nxt;
            if (state == IDLE && bus.cfg_wr_en)
                cfg_tbl[bus.cfg_wr_addr] <= bus.cfg_wr_data;
            if (restart) begin
                idx       <= '0;
                pass_mask <= '0;
            end else if (state == RUN && bus.ind)
                pass_mask[idx] <= 1'b1;
            else if (state == NEXT && !last)
                idx <= idx + 1'b1;
        end
    end

    cntr_seq_timer #(.TIMEOUT(TIMEOUT)) u_timer (
        .clk     (clk),
        .reset   (reset),
        .clr     (state == LOAD),
        .en      (state == RUN),
        .expired (expired)
    );

    assign entry          = cfg_tbl[idx];
    assign bus.cntr_start = CNT_W'(unpack_field(ENTRY_W'(entry), START_SLOT, CNT_W));
    assign bus.ind_val    = CNT_W'(unpack_field(ENTRY_W'(entry), IND_SLOT, CNT_W));
    assign bus.incr       = CNT_W'(unpack_field(ENTRY_W'(entry), INCR_SLOT, CNT_W));
    assign bus.busy       = busy;
    assign bus.done       = done;
    assign bus.cntr_reset = cntr_reset;
    assign bus.pass_mask  = pass_mask;

endmodule

// File: tb/tb_cntr_cfg_sequencer.sv
// tb_cntr_cfg_sequencer: randomized sequences checked against a per-entry cycle/pass model.
module tb_cntr_cfg_sequencer;
    localparam int NC = 4;
    localparam int W  = 4;
    localparam int TO = 16;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int n_chk = 0;
    int n_fail = 0;
    logic [3*W-1:0] tbl [NC];

    cntr_seq_if #(.NUM_CFG(NC), .CNT_W(W)) bus();

    cntr_cfg_sequencer #(.NUM_CFG(NC), .CNT_W(W), .TIMEOUT(TO)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_outs(input string tag, input int e);
        check({tag, "_start"}, 32'(bus.cntr_start), 32'(tbl[e][3*W-1:2*W]));
        check({tag, "_ind_val"}, 32'(bus.ind_val), 32'(tbl[e][2*W-1:W]));
        check({tag, "_incr"}, 32'(bus.incr), 32'(tbl[e][W-1:0]));
    endtask

    task automatic wr(input int a, input logic [3*W-1:0] d);
        @(negedge clk);
        bus.cfg_wr_en = 1'b1;
        bus.cfg_wr_addr = 2'(a);
        bus.cfg_wr_data = d;
        tbl[a] = d;
        @(negedge clk);
        bus.cfg_wr_en = 1'b0;
    endtask

    // k[e] = RUN cycle on which ind is raised for entry e; outside 1..TO means never.
    task automatic run_seq(input int k[NC], input bit disturb, input bit wr_go);
        int cyc = 0, e = -1, j = 0, exp_cyc = 1;
        int len[NC], exp_len[NC];
        logic prev = 1'b1;
        bit seen = 1'b0;
        logic [NC-1:0] exp_mask = '0;
        logic [3*W-1:0] d;
        for (int i = 0; i < NC; i++) begin
            exp_len[i] = (k[i] >= 1 && k[i] <= TO) ? k[i] : TO;
            exp_mask[i] = k[i] >= 1 && k[i] <= TO;
            exp_cyc += 2 + exp_len[i];
            len[i] = -1;
        end
        @(negedge clk);
        bus.go = 1'b1;
        if (wr_go) begin
            d = 12'($urandom);
            bus.cfg_wr_en = 1'b1;
            bus.cfg_wr_addr = '0;
            bus.cfg_wr_data = d;
            tbl[0] = d;
        end
        while (!seen && cyc < 400) begin
            @(negedge clk);
            cyc++;
            bus.go = 1'b0;
            bus.cfg_wr_en = 1'b0;
            if (disturb && cyc == 5) begin
                bus.go = 1'b1;
                bus.cfg_wr_en = 1'b1;
                bus.cfg_wr_addr = 2'($urandom);
                bus.cfg_wr_data = 12'($urandom);
            end
            if (bus.done)
                seen = 1'b1;
            else if (!bus.cntr_reset) begin
                if (prev) begin
                    e++;
                    j = 0;
                    if (e < NC) check_outs("entry", e);
                    check("busy_run", 32'(bus.busy), 1);
                end
                j++;
            end else if (!prev && e >= 0 && e < NC)
                len[e] = j;
            bus.ind = (!bus.cntr_reset && e >= 0 && e < NC) ? (j == k[e]) : 1'b0;
            prev = bus.cntr_reset;
        end
        bus.ind = 1'b0;
        check("done_seen", 32'(seen), 1);
        check("seq_cycles", cyc, exp_cyc);
        check("pass_mask", 32'(bus.pass_mask), 32'(exp_mask));
        check("busy_at_done", 32'(bus.busy), 0);
        for (int i = 0; i < NC; i++) check("run_len", len[i], exp_len[i]);
        @(negedge clk);
        check("done_width", 32'(bus.done), 0);
        check("idle_busy", 32'(bus.busy), 0);
        check("mask_hold", 32'(bus.pass_mask), 32'(exp_mask));
        check_outs("idle", NC - 1);
    endtask

    task automatic reset_mid();
        int e = -1, j = 0;
        logic prev = 1'b1;
        bit saw = 1'b0;
        @(negedge clk);
        bus.go = 1'b1;
        for (int c = 0; c < 100 && !(e == 1 && j == 2); c++) begin
            @(negedge clk);
            bus.go = 1'b0;
            if (!bus.cntr_reset) begin
                if (prev) begin
                    e++;
                    j = 0;
                end
                j++;
            end
            prev = bus.cntr_reset;
        end
        check("reached_entry1", e, 1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < NC; i++) tbl[i] = '0;
        check("rst_busy", 32'(bus.busy), 0);
        check("rst_done", 32'(bus.done), 0);
        check("rst_cntr_reset", 32'(bus.cntr_reset), 1);
        check("rst_mask", 32'(bus.pass_mask), 0);
        check_outs("rst", 0);
        repeat (30) begin
            @(negedge clk);
            if (bus.done || bus.busy) saw = 1'b1;
        end
        check("no_done_after_rst", 32'(saw), 0);
    endtask

`ifdef CNTR_SEQ_LOOP_EN
    task automatic loop_test();
        int cyc = 0, last_done = -1, pulses = 0;
        bit seen = 1'b0;
        @(negedge clk);
        bus.go = 1'b1;
        while (pulses < 3 && cyc < 200) begin
            @(negedge clk);
            cyc++;
            bus.ind = !bus.cntr_reset;
            check("loop_busy", 32'(bus.busy), 1);
            if (bus.done) begin
                pulses++;
                check("loop_mask", 32'(bus.pass_mask), 32'({NC{1'b1}}));
                if (last_done >= 0) check("loop_period", cyc - last_done, 13);
                last_done = cyc;
            end
        end
        check("loop_pulses", pulses, 3);
        repeat (3) begin
            @(negedge clk);
            bus.ind = !bus.cntr_reset;
        end
        bus.go = 1'b0;
        for (int c = 0; c < 50 && !seen; c++) begin
            @(negedge clk);
            bus.ind = !bus.cntr_reset;
            seen = bus.done;
        end
        bus.ind = 1'b0;
        check("loop_final_done", 32'(seen), 1);
        check("loop_final_busy", 32'(bus.busy), 0);
        @(negedge clk);
        check("loop_idle", 32'(bus.busy), 0);
        check("loop_idle_done", 32'(bus.done), 0);
    endtask
`endif

    initial begin
        int ks[NC];
        bus.cfg_wr_en = 1'b0;
        bus.cfg_wr_addr = '0;
        bus.cfg_wr_data = '0;
        bus.go = 1'b0;
        bus.ind = 1'b0;
        for (int i = 0; i < NC; i++) tbl[i] = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_cntr_reset", 32'(bus.cntr_reset), 1);
        check("reset_busy", 32'(bus.busy), 0);
        check("reset_done", 32'(bus.done), 0);
        check("reset_mask", 32'(bus.pass_mask), 0);
        check_outs("reset", 0);
        reset = 1'b0;

        wr(0, {4'd2, 4'd10, 4'd2});
        wr(1, {4'd1, 4'd12, 4'd3});
        wr(2, {4'd0, 4'd5, 4'd1});
        wr(3, {4'd3, 4'd7, 4'd1});
        check_outs("written_idle", 0);

        ks = '{4, 4, 4, 4};
        run_seq(ks, 1'b0, 1'b0);
        ks = '{4, 4, 0, 16};
        run_seq(ks, 1'b0, 1'b0);
        ks = '{2, 0, 16, 1};
        run_seq(ks, 1'b1, 1'b0);

        for (int r = 0; r < 6; r++) begin
            for (int i = 0; i < NC; i++) wr(i, 12'($urandom));
            for (int i = 0; i < NC; i++) ks[i] = int'($urandom_range(0, TO + 2));
            run_seq(ks, r[0], r % 3 == 0);
        end

        reset_mid();
`ifdef CNTR_SEQ_LOOP_EN
        loop_test();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/cntr_cfg_sequencer.md
Name: cntr_cfg_sequencer

Overview:
- Controller that sequences the team's configurable counter (`cntr_config`) through a table of NUM_CFG configurations.
- Each configuration is a (cntr_start, ind_val, incr) triple.
- For each entry the block loads the triple, pulses the counter reset, then watches `ind` for up to TIMEOUT cycles and records pass or fail.
- Sits between a host write port and one external `cntr_config` instance. The bench drives `ind` directly.

Parameters:
- NUM_CFG, 4: number of configuration entries; power of 2, at least 2.
- CNT_W, 4: width of the counter fields.
- TIMEOUT, 16: maximum RUN cycles per entry before it is declared failed; at least 1.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- reset  in  1  synchronous, active-high reset.
- cfg_wr_en  in  1  table write strobe.
- cfg_wr_addr  in  log2(NUM_CFG)  table write index.
- cfg_wr_data  in  3*CNT_W  packed {start, ind_val, incr}, with start in the MSBs.
- go  in  1  start a sequence run.
- ind  in  1  indicator from the counter.
- cntr_reset  out  1  reset to the counter.
- cntr_start  out  CNT_W  start value of the current entry.
- ind_val  out  CNT_W  target value of the current entry.
- incr  out  CNT_W  increment of the current entry.
- busy  out  1  a sequence is in progress.
- done  out  1  one-cycle pulse at the end of a sequence.
- pass_mask  out  NUM_CFG  bit i set means entry i reached `ind`.

Behaviour:
- Reset values:
  - State IDLE, idx=0, table entries all 0, timer=0.
  - pass_mask=0, busy=0, done=0, cntr_reset=1.
- Outputs cntr_start, ind_val and incr are always combinational from table[idx], with no extra latency.
- cntr_reset=1 in IDLE, LOAD, NEXT and DONE; 0 only in RUN. The counter therefore loads its start value on the edge that leaves LOAD.
- Table writes are accepted only in IDLE. Writes while busy=1 are ignored, with no error.
- State IDLE:
  - busy=0.
  - If go=1: idx<=0, pass_mask<=0, go to LOAD.
  - go=1 together with cfg_wr_en=1 in the same cycle: the write happens first, and the new value is used.
- State LOAD: one cycle, busy=1, timer<=0, go to RUN.
- State RUN: busy=1; `ind` is sampled every cycle.
  - ind=1: pass_mask[idx]<=1, go to NEXT.
  - Else if timer==TIMEOUT-1: pass_mask[idx] stays 0, go to NEXT.
  - Else: timer<=timer+1.
  - ind=1 in the same cycle as the timeout: pass wins.
  - RUN lasts at most TIMEOUT cycles.
- State NEXT: one cycle.
  - If idx==NUM_CFG-1: go to DONE.
  - Else: idx<=idx+1, go to LOAD.
- State DONE: done=1 and busy=0 for one cycle, then go to IDLE.
- pass_mask holds its value until the next accepted go or reset.
- go while busy is ignored.
- idx wraps naturally; no arithmetic overflow is possible.
- Timer width is clog2(TIMEOUT+1).
- Reset asserted mid-sequence: on the next edge all reset values apply, including a cleared table. No done pulse is generated.
- Latency per entry: 1 (LOAD) + k (RUN, 1..TIMEOUT) + 1 (NEXT) cycles; DONE adds 1 cycle at the end.

Optional Feature:
- Macro: CNTR_SEQ_LOOP_EN.
- Defined:
  - In DONE, if go=1 the block pulses done, clears pass_mask, sets idx<=0 and goes to LOAD instead of IDLE.
  - busy stays 1 across the loop boundary.
  - Looping continues until go=0 is seen in DONE.
- Undefined: DONE always returns to IDLE, as specified above.

Decomposition:
- Package cntr_seq_pkg:
  - State enum {IDLE, LOAD, RUN, NEXT, DONE}.
  - Field offset constants for the cfg_wr_data packing.
  - A function to unpack an entry.
- Sub-module cntr_seq_timer:
  - Clear/enable timeout counter with a `expired` output at TIMEOUT-1.
  - Instantiated once.
- The table is a plain register array inside the top module.

Test Plan:
- Reset check (NUM_CFG=4, TIMEOUT=16):
  - Stimulus: assert reset 2 cycles.
  - Required: cntr_reset=1, busy=0, done=0, pass_mask=4'b0000, cntr_start/ind_val/incr=0.
- Write and inspect:
  - Stimulus: write entry0={2,10,2} and entry1={1,12,3}.
  - Required: in IDLE, outputs show 2/10/2. After go and the first NEXT, outputs show 1/12/3.
- All pass:
  - Stimulus: go; bench raises ind on RUN cycle 4 for every entry.
  - Required: pass_mask=4'b1111, done pulse exactly 1 cycle, total sequence 4*(1+4+1)+1=25 cycles from go.
- Timeout boundary:
  - Stimulus: entry2 never sees ind; entry3 sees ind on RUN cycle 16 (the timeout cycle).
  - Required: pass_mask[2]=0, pass_mask[3]=1, entry2 RUN is exactly 16 cycles.
- Robustness:
  - Stimulus 1: cfg_wr_en and a second go pulse while busy.
  - Required: table unchanged and the sequence is not restarted.
  - Stimulus 2: reset asserted during RUN of entry1.
  - Required: IDLE next cycle, table zeroed, no done pulse.
- Loop (CNTR_SEQ_LOOP_EN defined):
  - Stimulus: go held high.
  - Required: done pulses every sequence and busy stays 1. Dropping go returns the block to IDLE after the next DONE.
